snd_wavetable: RTL and testbench

- Parametrised successor of the N163 expansion-audio block for mapper cores.
- Provides shared wave/register RAM with CPU address-port access, and a time-multiplexed sequencer that steps up to NCH wavetable channels.
- Outputs a per-slot legacy volume sample plus a per-frame summed mix.
- Sits between the mapper's CPU decode and the cartridge audio DAC path.

---
 rtl/snd_wt_pkg.sv | 26 ++
 rtl/snd_wt_ram.sv | 35 +++
 rtl/snd_wavetable.sv | 170 +++++++++++++++++
 tb/tb_snd_wavetable.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/snd_wt_pkg.sv
// Shared constants, sequencer step encoding and helpers for the wavetable sound block.
package snd_wt_pkg;

  localparam logic [2:0] FREQ_L  = 3'd0;
  localparam logic [2:0] PHASE_L = 3'd1;
  localparam logic [2:0] FREQ_M  = 3'd2;
  localparam logic [2:0] PHASE_M = 3'd3;
  localparam logic [2:0] FREQ_H  = 3'd4;
  localparam logic [2:0] PHASE_H = 3'd5;
  localparam logic [2:0] WAVE    = 3'd6;
  localparam logic [2:0] VOL     = 3'd7;

  localparam logic [4:0] ADDR_PORT = 5'h1F;
  localparam logic [4:0] DATA_PORT = 5'h09;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, S12, S13, S14, S15
  } step_t;

  // Wave length in samples: 256 - 4*len (len = 0 gives the full 256).
  function automatic logic [8:0] wave_len(input logic [5:0] len);
    return 9'd256 - {1'b0, len, 2'b00};
  endfunction

endpackage

// File: rtl/snd_wt_ram.sv
// Byte RAM: one write port, two independently enabled registered read ports.
module snd_wt_ram #(
  parameter int RAM_AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              a_en,
  input  logic [RAM_AW-1:0] a_addr,
  output logic [7:0]        a_data,
  input  logic              b_en,
  input  logic [RAM_AW-1:0] b_addr,
  output logic [7:0]        b_data
);

  logic [7:0] mem [0:2**RAM_AW-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output registers are reset; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= 8'd0;
      b_data <= 8'd0;
    end else begin
      if (a_en) a_data <= mem[a_addr];
      if (b_en) b_data <= mem[b_addr];
    end
  end

endmodule

// File: rtl/snd_wavetable.sv
// Wavetable expansion-audio block: CPU address/data port into shared RAM plus
// a 16-step-per-channel sequencer producing per-slot samples and a frame mix.
module snd_wavetable
  import snd_wt_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int RAM_AW = 7,
  parameter int MIX_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snd_tick,
  input  logic             cpu_stb,
  input  logic             cpu_rw,
  input  logic [4:0]       cpu_addr_hi,
  input  logic [7:0]       cpu_din,
  output logic [7:0]       cpu_dout,
  output logic [7:0]       vol,
  output logic [MIX_W-1:0] mix,
  output logic             mix_vld
);

  localparam int DEPTH = 2**RAM_AW;

  logic [RAM_AW-1:0] ptr;
  logic              auto_inc;
  logic              addr_sel, data_sel, cpu_we, cpu_re;

  step_t             step;
  logic [2:0]        ch;
  logic [3:0]        n_act;
  logic [17:0]       freq;
  logic [23:0]       phase;
  logic [7:0]        phase_old;
  logic [5:0]        len;
  logic [7:0]        wave_addr;
  logic [3:0]        ch_vol;
  logic              nib_sel;
  logic [3:0]        sample;
  logic [MIX_W-1:0]  acc;

  logic [RAM_AW-1:0] base, seq_raddr, seq_waddr;
  logic [7:0]        seq_wdata, seq_rdata, wsum, prod;
  logic              wb_step, seq_we, hold, last_ch;
  logic [23:0]       psum, phase_calc;
  logic [8:0]        wlen;
  logic [3:0]        req_cnt;

  assign addr_sel = cpu_stb && (cpu_addr_hi == ADDR_PORT);
  assign data_sel = cpu_stb && (cpu_addr_hi == DATA_PORT);
  assign cpu_we   = data_sel && !cpu_rw;
  assign cpu_re   = data_sel && cpu_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      auto_inc <= 1'b0;
    end else if (addr_sel && !cpu_rw) begin
      ptr      <= cpu_din[RAM_AW-1:0];
      auto_inc <= cpu_din[7];
    end else if (data_sel && auto_inc) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign base    = RAM_AW'(DEPTH - 8 * (32'(ch) + 1));
  // Sample is addressed with the phase as fetched at the start of the slot.
  assign wsum    = phase_old + wave_addr;
  assign wb_step = (step == S10) || (step == S11) || (step == S12);
  assign seq_we  = snd_tick && wb_step && !cpu_we;
  assign hold    = snd_tick && wb_step && cpu_we;

  always_comb begin
    seq_raddr = base + RAM_AW'(step[2:0]);
    if (step == S13) seq_raddr = RAM_AW'(wsum[7:1]);
  end

  always_comb begin
    seq_waddr = base + RAM_AW'(PHASE_H);
    seq_wdata = phase[23:16];
    if (step == S10) begin
      seq_waddr = base + RAM_AW'(PHASE_L);
      seq_wdata = phase[7:0];
    end else if (step == S11) begin
      seq_waddr = base + RAM_AW'(PHASE_M);
      seq_wdata = phase[15:8];
    end
  end

  snd_wt_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cpu_we || seq_we),
    .waddr  (cpu_we ? ptr : seq_waddr),
    .wdata  (cpu_we ? cpu_din : seq_wdata),
    .a_en   (cpu_re),
    .a_addr (ptr),
    .a_data (cpu_dout),
    .b_en   (snd_tick),
    .b_addr (seq_raddr),
    .b_data (seq_rdata)
  );

  assign psum       = phase + {6'd0, freq};
  assign wlen       = wave_len(len);
  assign phase_calc = ({1'b0, psum[23:16]} >= wlen) ?
                      {psum[23:16] - wlen[7:0], psum[15:0]} : psum;
  assign prod       = {4'd0, sample} * {4'd0, ch_vol};
  assign last_ch    = ({1'b0, ch} == (n_act - 4'd1));
  assign req_cnt    = {1'b0, seq_rdata[6:4]} + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= S0;
      ch        <= 3'd0;
      n_act     <= 4'd1;
      freq      <= '0;
      phase     <= '0;
      phase_old <= '0;
      len       <= '0;
      wave_addr <= '0;
      ch_vol    <= '0;
      nib_sel   <= 1'b0;
      sample    <= '0;
      acc       <= '0;
      vol       <= '0;
      mix       <= '0;
      mix_vld   <= 1'b0;
    end else begin
      mix_vld <= 1'b0;
      if (snd_tick && !hold) begin
        step <= step_t'(step + 4'd1);
        case (step)
          S1: freq[7:0]   <= seq_rdata;
          S2: phase[7:0]  <= seq_rdata;
          S3: freq[15:8]  <= seq_rdata;
          S4: phase[15:8] <= seq_rdata;
          S5: {len, freq[17:16]} <= seq_rdata;
          S6: begin
            phase[23:16] <= seq_rdata;
            phase_old    <= seq_rdata;
          end
          S7: wave_addr <= seq_rdata;
          S8: begin
            ch_vol <= seq_rdata[3:0];
            // Channel 0's last byte is the top RAM byte: frame-start count sample.
            if (ch == 3'd0) n_act <= (req_cnt > 4'(NCH)) ? 4'(NCH) : req_cnt;
          end
          S9:  phase   <= phase_calc;
          S13: nib_sel <= wsum[0];
          S14: sample  <= nib_sel ? seq_rdata[7:4] : seq_rdata[3:0];
          S15: begin
            vol <= prod;
            if (last_ch) begin
              mix     <= acc + MIX_W'(prod);
              mix_vld <= 1'b1;
              acc     <= '0;
              ch      <= 3'd0;
            end else begin
              acc <= acc + MIX_W'(prod);
              ch  <= ch + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snd_wavetable.sv
// Directed bench for snd_wavetable: CPU port, slot arithmetic, frame mix, write conflict, reset.
module tb_snd_wavetable;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd_tick;
  logic        cpu_stb;
  logic        cpu_rw;
  logic [4:0]  cpu_addr_hi;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic [7:0]  vol;
  logic [10:0] mix;
  logic        mix_vld;

  int n_cmp = 0;
  int n_err = 0;

  snd_wavetable #(.NCH(8), .RAM_AW(7), .MIX_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .snd_tick    (snd_tick),
    .cpu_stb     (cpu_stb),
    .cpu_rw      (cpu_rw),
    .cpu_addr_hi (cpu_addr_hi),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .vol         (vol),
    .mix         (mix),
    .mix_vld     (mix_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Hold the given inputs across exactly one rising edge; returns at the next falling edge.
  task automatic drive(input logic t, input logic s, input logic rw,
                       input logic [4:0] hi, input logic [7:0] d);
    snd_tick    = t;
    cpu_stb     = s;
    cpu_rw      = rw;
    cpu_addr_hi = hi;
    cpu_din     = d;
    @(negedge clk);
    snd_tick = 1'b0;
    cpu_stb  = 1'b0;
    cpu_rw   = 1'b0;
  endtask

  task automatic set_addr(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, 5'h1F, d);
  endtask

  task automatic wr(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, 5'h09, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    drive(1'b0, 1'b1, 1'b1, 5'h09, 8'h00);
    check(tag, 16'(cpu_dout), 16'(exp));
  endtask

  task automatic rd_at(input string tag, input logic [6:0] a, input logic [7:0] exp);
    set_addr({1'b0, a});
    rd_chk(tag, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; snd_tick = 1'b0; cpu_stb = 1'b0; cpu_rw = 1'b0;
    cpu_addr_hi = 5'h00; cpu_din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_vol", 16'(vol), 16'h0);
    check("rst_mix", 16'(mix), 16'h0);
    check("rst_mix_vld", 16'(mix_vld), 16'h0);
    check("rst_cpu_dout", 16'(cpu_dout), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Auto-increment writes, then read back from 0
    set_addr(8'h80);
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    set_addr(8'h80);
    rd_chk("rd0", 8'h11);
    rd_chk("rd1", 8'h22);
    rd_chk("rd2", 8'h33);
    rd_chk("rd3_ptr3", 8'h44);

    // Pointer wrap at top of RAM
    set_addr(8'hFF);
    wr(8'hAA); wr(8'hBB);
    rd_at("wrap_7f", 7'h7F, 8'hAA);
    rd_at("wrap_00", 7'h00, 8'hBB);

    // Channel 0 alone: freq 0x010000, len 62, phase_hi 7, vol 15, wave byte 3 = 5A
    set_addr(8'hF8);
    wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h00);
    wr(8'hF9); wr(8'h07); wr(8'h00); wr(8'h0F);
    set_addr(8'h03); wr(8'h5A);
    ticks(15);
    check("slot_s14_vol", 16'(vol), 16'h0);
    check("slot_s14_mix_vld", 16'(mix_vld), 16'h0);
    ticks(1);
    check("slot_vol", 16'(vol), 16'd75);
    check("slot_mix", 16'(mix), 16'd75);
    check("slot_mix_vld", 16'(mix_vld), 16'h1);
    drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    check("slot_mix_vld_pulse", 16'(mix_vld), 16'h0);
    rd_at("slot_phase_wrap", 7'h7D, 8'h00);

    // Two channels: ch1 vol 9 at 0x70.., ch0 vol 6 with count field 1
    set_addr(8'hF0);
    wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h00);
    wr(8'hF9); wr(8'h07); wr(8'h00); wr(8'h09);
    wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h00);
    wr(8'hF9); wr(8'h07); wr(8'h00); wr(8'h16);
    ticks(16);
    check("fa_ch0_vol", 16'(vol), 16'd30);
    check("fa_ch0_mix_vld", 16'(mix_vld), 16'h0);
    ticks(16);
    check("fa_ch1_vol", 16'(vol), 16'd45);
    check("fa_mix", 16'(mix), 16'd75);
    check("fa_mix_vld", 16'(mix_vld), 16'h1);
    // Second frame: both phases at 0 -> low nibble of RAM[0]=BB -> 11
    ticks(16);
    check("fb_ch0_vol", 16'(vol), 16'd66);
    check("fb_ch0_mix_vld", 16'(mix_vld), 16'h0);
    ticks(16);
    check("fb_ch1_vol", 16'(vol), 16'd99);
    check("fb_mix", 16'(mix), 16'd165);
    check("fb_mix_vld", 16'(mix_vld), 16'h1);

    // CPU write collides with ch0 S10 write-back
    set_addr(8'h78); wr(8'h34);
    set_addr(8'h10);
    ticks(10);
    drive(1'b1, 1'b1, 1'b0, 5'h09, 8'hC3);
    ticks(5);
    check("conf_held_vol", 16'(vol), 16'd99);
    ticks(1);
    check("conf_vol", 16'(vol), 16'd66);
    rd_at("conf_cpu_byte", 7'h10, 8'hC3);
    rd_at("conf_phase_l", 7'h79, 8'h34);
    rd_at("conf_phase_m", 7'h7B, 8'h00);
    rd_at("conf_phase_h", 7'h7D, 8'h02);

    // Reset during ch1 S11
    ticks(11);
    rst_n = 1'b0;
    #1;
    check("mrst_vol", 16'(vol), 16'h0);
    check("mrst_mix", 16'(mix), 16'h0);
    check("mrst_mix_vld", 16'(mix_vld), 16'h0);
    check("mrst_cpu_dout", 16'(cpu_dout), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Restart at ch0: phase_hi 2 -> low nibble of RAM[1]=22 -> 2*6
    ticks(16);
    check("restart_vol", 16'(vol), 16'd12);
    check("restart_mix", 16'(mix), 16'h0);
    check("restart_mix_vld", 16'(mix_vld), 16'h0);
    rd_at("restart_phase_l", 7'h79, 8'h68);
    rd_at("restart_phase_h", 7'h7D, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
